// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger window readout path: FSM encoding and
// output FIFO sizing constants.
package trigger_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      READ,
      DRAIN,
      DONE
   } state_t;

   localparam int DEF_FIFO_DEPTH = 4;

   function automatic int fifo_ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int DEF_FIFO_PTR_W = fifo_ptr_w(DEF_FIFO_DEPTH);

endpackage

// File: rtl/axis_skid_fifo.sv
// Small single-clock FIFO with an AXI-stream style output, occupancy count
// and a synchronous flush that discards everything, including a same-cycle push.
module axis_skid_fifo
   import trigger_pkg::*;
#(
   parameter int WIDTH = 17,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          wr_en,
   input  logic [WIDTH-1:0]              wr_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_data,
   output logic [fifo_ptr_w(DEPTH):0]    count
);

   localparam int PTR_W = fifo_ptr_w(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push;
   logic             pop;

   assign out_valid = (count != '0);
   assign pop       = out_valid && out_ready;
   assign push      = wr_en && ((count != FULL_CNT) || pop);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;

   // NOTE: storage has no reset; only pointers and count define which entries are live.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/trigger_window_reader.sv
// Reads a pre/post-trigger window out of a circular sample buffer and streams
// it over AXI-stream, with credit-based flow control into a skid FIFO.
module trigger_window_reader
   import trigger_pkg::*;
#(
   parameter int DATA_WIDTH      = 16,
   parameter int MEMORY_ADDR_LEN = 32,
   parameter int BUF_ADDR_WIDTH  = 12,
   parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        abort,
   input  logic [MEMORY_ADDR_LEN-1:0]  trigger_offset,
   input  logic [MEMORY_ADDR_LEN-1:0]  buf_base,
   input  logic [BUF_ADDR_WIDTH:0]     buf_depth,
   input  logic [BUF_ADDR_WIDTH:0]     pretrig_len,
   input  logic [BUF_ADDR_WIDTH:0]     window_len,
   output logic                        rd_en,
   output logic [BUF_ADDR_WIDTH-1:0]   rd_addr,
   input  logic [DATA_WIDTH-1:0]       rd_data,
   output logic [DATA_WIDTH-1:0]       m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast,
   output logic                        busy,
   output logic                        done,
   output logic                        cfg_error
);

   localparam int IDX_W      = BUF_ADDR_WIDTH + 1;
   localparam int BYTE_SHIFT = $clog2(DATA_WIDTH / 8);
   localparam int CNT_W      = fifo_ptr_w(FIFO_DEPTH) + 1;

   state_t                      state;
   logic [MEMORY_ADDR_LEN-1:0]  cfg_trig;
   logic [MEMORY_ADDR_LEN-1:0]  cfg_base;
   logic [IDX_W-1:0]            cfg_depth;
   logic [IDX_W-1:0]            cfg_pre;
   logic [IDX_W-1:0]            cfg_win;
   logic [IDX_W-1:0]            rd_remaining;
   logic                        rd_last;
   logic                        wr_en;
   logic                        wr_last;

   logic [MEMORY_ADDR_LEN-1:0]  byte_delta;
   logic [IDX_W-1:0]            trig_idx;
   logic [IDX_W-1:0]            start_idx;
   logic [BUF_ADDR_WIDTH-1:0]   next_addr;
   logic                        cfg_bad;
   logic                        credit_ok;
   logic                        flush;
   logic                        fifo_pop;
   logic                        fifo_last;
   logic [CNT_W-1:0]            fifo_count;

   assign byte_delta = cfg_trig - cfg_base;
   assign trig_idx   = IDX_W'(byte_delta >> BYTE_SHIFT);
   assign cfg_bad    = (cfg_win == '0) || (cfg_win > cfg_depth) || (cfg_pre >= cfg_win)
                    || (trig_idx >= cfg_depth) || (cfg_depth == '0);
   assign start_idx  = (trig_idx >= cfg_pre) ? trig_idx - cfg_pre
                                             : trig_idx + cfg_depth - cfg_pre;
   assign next_addr  = ({1'b0, rd_addr} == cfg_depth - 1'b1) ? '0 : rd_addr + 1'b1;
   assign flush      = abort && (state != IDLE);
   assign fifo_pop   = m_axis_tvalid && m_axis_tready;

   // A new read is allowed only if, after this edge, every slot it could land in is still free.
   // NOTE: every output of an always_comb gets a default first so no latch is inferred.
   always_comb begin
      credit_ok = 1'b0;
      if (int'(fifo_count) - int'(fifo_pop) + int'(wr_en) + int'(rd_en) < FIFO_DEPTH) begin
         credit_ok = 1'b1;
      end
   end

   // NOTE: all state here updates with <= so every branch sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cfg_trig     <= '0;
         cfg_base     <= '0;
         cfg_depth    <= '0;
         cfg_pre      <= '0;
         cfg_win      <= '0;
         rd_remaining <= '0;
         rd_en        <= 1'b0;
         rd_addr      <= '0;
         rd_last      <= 1'b0;
         wr_en        <= 1'b0;
         wr_last      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         cfg_error    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (flush) begin
            state   <= IDLE;
            rd_en   <= 1'b0;
            rd_last <= 1'b0;
            wr_en   <= 1'b0;
            wr_last <= 1'b0;
            busy    <= 1'b0;
         end else begin
            wr_en   <= rd_en;
            wr_last <= rd_last;
            case (state)
               IDLE: begin
                  if (start) begin
                     cfg_trig  <= trigger_offset;
                     cfg_base  <= buf_base;
                     cfg_depth <= buf_depth;
                     cfg_pre   <= pretrig_len;
                     cfg_win   <= window_len;
                     busy      <= 1'b1;
                     state     <= CHECK;
                  end
               end
               CHECK: begin
                  if (cfg_bad) begin
                     cfg_error <= 1'b1;
                     busy      <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     cfg_error    <= 1'b0;
                     rd_en        <= 1'b1;
                     rd_addr      <= BUF_ADDR_WIDTH'(start_idx);
                     rd_remaining <= cfg_win - 1'b1;
                     rd_last      <= (cfg_win == IDX_W'(1));
                     state        <= READ;
                  end
               end
               READ: begin
                  if (rd_remaining == '0) begin
                     rd_en   <= 1'b0;
                     rd_last <= 1'b0;
                     state   <= DRAIN;
                  end else if (credit_ok) begin
                     rd_en        <= 1'b1;
                     rd_addr      <= next_addr;
                     rd_remaining <= rd_remaining - 1'b1;
                     rd_last      <= (rd_remaining == IDX_W'(1));
                  end else begin
                     rd_en   <= 1'b0;
                     rd_last <= 1'b0;
                  end
               end
               DRAIN: begin
                  if (fifo_pop && fifo_last) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
               DONE: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
               default: begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   axis_skid_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .wr_en     (wr_en),
      .wr_data   ({wr_last, rd_data}),
      .out_valid (m_axis_tvalid),
      .out_ready (m_axis_tready),
      .out_data  ({fifo_last, m_axis_tdata}),
      .count     (fifo_count)
   );

   assign m_axis_tlast = fifo_last;

endmodule

// File: tb/tb_trigger_window_reader.sv
// Randomized and directed bench for trigger_window_reader against a queue-based window model.
module tb_trigger_window_reader;

   localparam int DW  = 16;
   localparam int AW  = 32;
   localparam int BAW = 12;
   localparam int FD  = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           start;
   logic           abort;
   logic [AW-1:0]  trigger_offset;
   logic [AW-1:0]  buf_base;
   logic [BAW:0]   buf_depth;
   logic [BAW:0]   pretrig_len;
   logic [BAW:0]   window_len;
   logic           rd_en;
   logic [BAW-1:0] rd_addr;
   logic [DW-1:0]  rd_data;
   logic [DW-1:0]  m_axis_tdata;
   logic           m_axis_tvalid;
   logic           m_axis_tready;
   logic           m_axis_tlast;
   logic           busy;
   logic           done;
   logic           cfg_error;

   logic [DW-1:0]  mem [1 << BAW];
   int             n_checks = 0;
   int             n_errors = 0;

   always #5 clk = ~clk;

   trigger_window_reader #(
      .DATA_WIDTH      (DW),
      .MEMORY_ADDR_LEN (AW),
      .BUF_ADDR_WIDTH  (BAW),
      .FIFO_DEPTH      (FD)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .abort          (abort),
      .trigger_offset (trigger_offset),
      .buf_base       (buf_base),
      .buf_depth      (buf_depth),
      .pretrig_len    (pretrig_len),
      .window_len     (window_len),
      .rd_en          (rd_en),
      .rd_addr        (rd_addr),
      .rd_data        (rd_data),
      .m_axis_tdata   (m_axis_tdata),
      .m_axis_tvalid  (m_axis_tvalid),
      .m_axis_tready  (m_axis_tready),
      .m_axis_tlast   (m_axis_tlast),
      .busy           (busy),
      .done           (done),
      .cfg_error      (cfg_error)
   );

   // Sample memory: data appears one cycle after the read strobe.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int model_idx(input int trig, input int base);
      longint d;
      d = (longint'(trig) - longint'(base)) & 64'hFFFF_FFFF;
      return int'((d / (DW / 8)) % (1 << (BAW + 1)));
   endfunction

   function automatic bit model_bad(input int trig, input int base, input int depth,
                                    input int pre, input int win);
      int idx;
      idx = model_idx(trig, base);
      return (win == 0) || (win > depth) || (pre >= win) || (idx >= depth) || (depth == 0);
   endfunction

   task automatic apply_cfg(input int base, input int trig, input int depth,
                            input int pre, input int win);
      buf_base       = base;
      trigger_offset = trig;
      buf_depth      = (BAW + 1)'(depth);
      pretrig_len    = (BAW + 1)'(pre);
      window_len     = (BAW + 1)'(win);
   endtask

   task automatic run_window(input int base, input int trig, input int depth, input int pre,
                             input int win, input int ready_mode, input int abort_beat,
                             input string nm);
      int idx, st, n_rd, n_beats, n_done, max_out, stray;
      int first_rd, first_vld, first_beat, last_beat, done_cyc, abort_cyc;
      int exp_addr[$];
      logic [DW-1:0] exp_data[$];
      logic prev_stall, prev_last;
      logic [DW-1:0] prev_data;
      bit aborted, stop;
      idx = model_idx(trig, base);
      st = ((idx - pre) % depth + depth) % depth;
      for (int k = 0; k < win; k++) begin
         exp_addr.push_back((st + k) % depth);
         exp_data.push_back(mem[(st + k) % depth]);
      end
      n_rd = 0; n_beats = 0; n_done = 0; max_out = 0; stray = 0;
      first_rd = -1; first_vld = -1; first_beat = -1; last_beat = -1;
      done_cyc = 0; abort_cyc = 0; aborted = 0; stop = 0;
      prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;

      @(posedge clk); #1;
      apply_cfg(base, trig, depth, pre, win);
      start = 1'b1;
      abort = 1'b0;
      for (int cyc = 0; cyc < 4000 && !stop; cyc++) begin
         if (cyc > 0) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
         end
         case (ready_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ((cyc % 3) == 0);
            default: m_axis_tready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (abort_beat > 0 && !aborted && m_axis_tvalid && m_axis_tready
             && n_beats + 1 == abort_beat) begin
            abort     = 1'b1;
            aborted   = 1;
            abort_cyc = cyc;
         end
         @(negedge clk);
         if (aborted && cyc > abort_cyc) begin
            if (rd_en || m_axis_tvalid || done || busy) stray++;
            if (cyc == abort_cyc + 1) begin
               check({nm, " tvalid after abort"}, m_axis_tvalid, 0);
               check({nm, " busy after abort"}, busy, 0);
            end
            if (cyc >= abort_cyc + 6) stop = 1;
         end else begin
            if (rd_en) begin
               if (first_rd < 0) first_rd = cyc;
               if (n_rd < win) check({nm, " rd_addr"}, rd_addr, exp_addr[n_rd]);
               else            check({nm, " extra read"}, n_rd + 1, win);
               n_rd++;
               if (n_rd - n_beats > max_out) max_out = n_rd - n_beats;
            end
            if (m_axis_tvalid && first_vld < 0) first_vld = cyc;
            if (prev_stall) begin
               check({nm, " tvalid held"}, m_axis_tvalid, 1);
               check({nm, " tdata held"}, m_axis_tdata, prev_data);
               check({nm, " tlast held"}, m_axis_tlast, prev_last);
            end
            if (m_axis_tvalid && m_axis_tready) begin
               n_beats++;
               if (n_beats <= win) begin
                  check({nm, " tdata"}, m_axis_tdata, exp_data[n_beats - 1]);
                  check({nm, " tlast"}, m_axis_tlast, (n_beats == win));
               end else begin
                  check({nm, " extra beat"}, n_beats, win);
               end
               if (first_beat < 0) first_beat = cyc;
               last_beat = cyc;
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            if (done) begin
               n_done++;
               if (n_done == 1) done_cyc = cyc;
            end
            if (n_done > 0 && cyc >= done_cyc + 3) stop = 1;
         end
      end
      m_axis_tready = 1'b1;
      check({nm, " occupancy bound"}, (max_out <= FD), 1);
      check({nm, " cfg_error"}, cfg_error, 0);
      check({nm, " busy at end"}, busy, 0);
      if (abort_beat > 0) begin
         check({nm, " abort reached"}, aborted, 1);
         check({nm, " beats before abort"}, n_beats, abort_beat);
         check({nm, " no done"}, n_done, 0);
         check({nm, " quiet after abort"}, stray, 0);
      end else begin
         check({nm, " reads"}, n_rd, win);
         check({nm, " beats"}, n_beats, win);
         check({nm, " done pulses"}, n_done, 1);
         if (ready_mode == 0) begin
            check({nm, " start->rd_en"}, first_rd, 2);
            check({nm, " rd_en->tvalid"}, first_vld - first_rd, 2);
            check({nm, " throughput"}, last_beat - first_beat, win - 1);
         end
      end
   endtask

   task automatic run_error(input int base, input int trig, input int depth, input int pre,
                            input int win, input string nm);
      int busy_cycles, reads, vlds;
      busy_cycles = 0; reads = 0; vlds = 0;
      @(posedge clk); #1;
      apply_cfg(base, trig, depth, pre, win);
      start = 1'b1;
      m_axis_tready = 1'b1;
      for (int cyc = 0; cyc < 8; cyc++) begin
         if (cyc > 0) begin
            @(posedge clk); #1;
            start = 1'b0;
         end
         @(negedge clk);
         if (busy) busy_cycles++;
         if (rd_en) reads++;
         if (m_axis_tvalid) vlds++;
      end
      check({nm, " cfg_error"}, cfg_error, 1);
      check({nm, " busy cycles"}, busy_cycles, 1);
      check({nm, " no reads"}, reads, 0);
      check({nm, " no tvalid"}, vlds, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int stray;
      rst = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      m_axis_tready = 1'b0;
      rd_data = '0;
      apply_cfg(0, 0, 0, 0, 0);
      for (int i = 0; i < (1 << BAW); i++) mem[i] = DW'($urandom);
      repeat (3) @(posedge clk);
      #1;
      check("reset rd_en", rd_en, 0);
      check("reset rd_addr", rd_addr, 0);
      check("reset tvalid", m_axis_tvalid, 0);
      check("reset tlast", m_axis_tlast, 0);
      check("reset tdata", m_axis_tdata, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset cfg_error", cfg_error, 0);
      rst = 1'b0;

      run_window(32'h1000, 32'h1010, 1024, 16, 64, 0, 0, "wrap");
      run_window(32'h1000, 32'h1010, 1024, 16, 64, 1, 0, "backpressure");
      run_error(32'h1000, 32'h1010, 1024, 0, 0, "err_win0");
      run_error(32'h1000, 32'h1010, 1024, 64, 64, "err_pre");
      run_error(32'h1000, 32'h1800, 1024, 16, 64, "err_trig");
      run_error(32'h1000, 32'h1000, 0, 0, 0, "err_depth0");
      run_window(32'h1000, 32'h1010, 1024, 16, 64, 0, 0, "recover");
      run_window(32'h1000, 32'h1010, 1024, 16, 64, 0, 30, "abort");
      run_window(32'h1000, 32'h1010, 1024, 16, 64, 0, 0, "post_abort");

      // Reset in the middle of a stalled readout with three samples buffered.
      @(posedge clk); #1;
      apply_cfg(32'h1000, 32'h1010, 1024, 16, 64);
      start = 1'b1;
      m_axis_tready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      check("pre-reset tvalid", m_axis_tvalid, 1);
      rst = 1'b1;
      #1;
      check("mid rst rd_en", rd_en, 0);
      check("mid rst rd_addr", rd_addr, 0);
      check("mid rst tvalid", m_axis_tvalid, 0);
      check("mid rst tlast", m_axis_tlast, 0);
      check("mid rst tdata", m_axis_tdata, 0);
      check("mid rst busy", busy, 0);
      check("mid rst done", done, 0);
      check("mid rst cfg_error", cfg_error, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      m_axis_tready = 1'b1;
      stray = 0;
      repeat (10) begin
         @(negedge clk);
         if (m_axis_tvalid || rd_en || busy || done) stray++;
      end
      check("quiet after reset", stray, 0);

      run_window(32'h2000, 32'h201E, 16, 0, 16, 0, 0, "full");

      for (int t = 0; t < 10; t++) begin
         int depth, win, pre, idx, base, trig;
         depth = $urandom_range(1, 200);
         win   = $urandom_range(0, depth + 4);
         pre   = $urandom_range(0, win + 1);
         idx   = $urandom_range(0, depth + 1);
         base  = int'($urandom);
         trig  = base + idx * (DW / 8) + int'($urandom_range(0, 1));
         if (model_bad(trig, base, depth, pre, win)) run_error(base, trig, depth, pre, win, "rand_err");
         else run_window(base, trig, depth, pre, win, 2, 0, "rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
